// File: rtl/types.sv
// rtl/types.sv - shared enums, reset vector and instruction-length decode for instr_sequencer
package types;

  typedef enum logic [1:0] {
    CYCLE5  = 2'd0,
    CYCLE7  = 2'd1,
    CYCLE12 = 2'd2
  } instr_length;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } seq_state;

  localparam logic [12:0] RESET_PC = 13'h0100;
  localparam int          CNT_W    = 4;

  function automatic logic [CNT_W-1:0] len_ticks(input instr_length l);
    case (l)
      CYCLE7:  return 4'd7;
      CYCLE12: return 4'd12;
      default: return 4'd5;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - per-instruction tick counter; flags the last EXEC tick (count == len-1)
module cycle_timer
  import types::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clk_en_i,
  input  logic        load_i,
  input  logic        run_i,
  input  instr_length len_i,
  output logic        final_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] len_q;

  // The FETCH tick counts as tick 0, so EXEC starts at 1.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
      len_q   <= '0;
    end else if (clk_en_i) begin
      if (load_i) begin
        count_q <= CNT_W'(1);
        len_q   <= len_ticks(len_i);
      end else if (run_i) begin
        count_q <= final_o ? '0 : count_q + CNT_W'(1);
      end
    end
  end

  assign final_o = run_i && (count_q == len_q - CNT_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - FETCH/EXEC(/HALT) instruction sequencer driving PC, opcode and microcode address
// Optional HALT/wake support is built when SEQ_HALT_EN is defined.
module instr_sequencer
  import types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [11:0] rom_data,
  input  logic [6:0]  microcode_start_addr,
  input  instr_length cycle_length,
  input  logic        skip_pc_increment,
  input  logic        micro_last,
  input  logic        pc_load,
  input  logic [12:0] pc_load_value,
  input  logic        halt_req,
  input  logic        wake,
  output logic [12:0] rom_addr,
  output logic [11:0] opcode,
  output logic [6:0]  microcode_addr,
  output logic        micro_valid,
  output logic        instr_start,
  output logic        halted
);

  seq_state    state_q;
  logic [12:0] pc_q;
  logic [12:0] pc_d;
  logic [12:0] jmp_val_q;
  logic        jmp_pend_q;
  logic [11:0] opcode_q;
  logic [6:0]  uaddr_q;
  logic        uvalid_q;
  logic        start_q;
  logic        halted_q;
  logic        skip_q;
  logic        last_tick;

  cycle_timer u_timer (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .clk_en_i (clk_en),
    .load_i   (state_q == FETCH),
    .run_i    (state_q == EXEC),
    .len_i    (cycle_length),
    .final_o  (last_tick)
  );

  // A jump on the final tick beats one captured earlier in the instruction.
  always_comb begin
    pc_d = pc_q;
    if (pc_load)         pc_d = pc_load_value;
    else if (jmp_pend_q) pc_d = jmp_val_q;
    else if (!skip_q)    pc_d = {pc_q[12:8], pc_q[7:0] + 8'd1};
  end

`ifndef SEQ_HALT_EN
  logic unused_halt_in;
  assign unused_halt_in = halt_req | wake;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      jmp_val_q  <= '0;
      jmp_pend_q <= 1'b0;
      opcode_q   <= '0;
      uaddr_q    <= '0;
      uvalid_q   <= 1'b0;
      start_q    <= 1'b0;
      halted_q   <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (clk_en) begin
        case (state_q)
          FETCH: begin
            opcode_q   <= rom_data;
            uaddr_q    <= microcode_start_addr;
            uvalid_q   <= 1'b1;
            skip_q     <= skip_pc_increment;
            jmp_pend_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= EXEC;
          end
          EXEC: begin
            if (uvalid_q) begin
              if (micro_last) uvalid_q <= 1'b0;
              else            uaddr_q  <= uaddr_q + 7'd1;
            end
            if (last_tick) begin
              pc_q       <= pc_d;
              jmp_pend_q <= 1'b0;
              uvalid_q   <= 1'b0;
`ifdef SEQ_HALT_EN
              state_q    <= halt_req ? HALT : FETCH;
              halted_q   <= halt_req;
`else
              state_q    <= FETCH;
`endif
            end else if (pc_load) begin
              jmp_pend_q <= 1'b1;
              jmp_val_q  <= pc_load_value;
            end
          end
`ifdef SEQ_HALT_EN
          HALT: begin
            if (wake) begin
              state_q  <= FETCH;
              halted_q <= 1'b0;
            end
          end
`endif
          default: state_q <= FETCH;
        endcase
      end
    end
  end

  assign rom_addr       = pc_q;
  assign opcode         = opcode_q;
  assign microcode_addr = uaddr_q;
  assign micro_valid    = uvalid_q;
  assign instr_start    = start_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer; halt checks follow SEQ_HALT_EN
module tb_instr_sequencer;
  import types::*;

  logic        clk = 1'b0;
  logic        reset_n, clk_en, skip_pc_increment, micro_last, pc_load, halt_req, wake;
  logic [11:0] rom_data;
  logic [6:0]  microcode_start_addr;
  instr_length cycle_length;
  logic [12:0] pc_load_value;
  logic [12:0] rom_addr;
  logic [11:0] opcode;
  logic [6:0]  microcode_addr;
  logic        micro_valid, instr_start, halted;

  instr_sequencer dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .clk_en               (clk_en),
    .rom_data             (rom_data),
    .microcode_start_addr (microcode_start_addr),
    .cycle_length         (cycle_length),
    .skip_pc_increment    (skip_pc_increment),
    .micro_last           (micro_last),
    .pc_load              (pc_load),
    .pc_load_value        (pc_load_value),
    .halt_req             (halt_req),
    .wake                 (wake),
    .rom_addr             (rom_addr),
    .opcode               (opcode),
    .microcode_addr       (microcode_addr),
    .micro_valid          (micro_valid),
    .instr_start          (instr_start),
    .halted               (halted)
  );

  always #5 clk = ~clk;

  // jt/jt2: ticks carrying pc_load (0 = none); ml: micro_last tick (0 = none)
  typedef struct {
    logic [11:0] op;
    logic [6:0]  sa;
    instr_length len;
    logic        skip;
    int          jt;
    logic [12:0] jv;
    int          jt2;
    logic [12:0] jv2;
    int          ml;
    logic        gate;
    int          exp_ticks;
    logic [12:0] exp_pc;
  } vec_t;

  typedef struct {
    int          ticks;
    logic [12:0] pc;
    logic [11:0] op;
  } exp_t;

  localparam int          N       = 9;
  localparam logic [11:0] FILL_OP = 12'h5C3;

  vec_t vt [N];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_decode(input int i);
    if (i < N) begin
      rom_data             = vt[i].op;
      microcode_start_addr = vt[i].sa;
      cycle_length         = vt[i].len;
      skip_pc_increment    = vt[i].skip;
    end else begin
      rom_data             = FILL_OP;
      microcode_start_addr = 7'h7F;
      cycle_length         = CYCLE5;
      skip_pc_increment    = 1'b0;
    end
  endtask

  task automatic run_to_fetch(input int limit, output int n);
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while (!instr_start && n < limit);
    if (!instr_start) n = -1;
  endtask

  function automatic logic [6:0] exp_ua(input logic [6:0] sa, input int t, input int m);
    return sa + 7'(t < m ? t : m - 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          m;
    int          n;
    bit          done;
    exp_t        e;
    exp_t        e_push;
    logic [12:0] pc_cur;

    vt[0] = '{12'h0A5, 7'h10, CYCLE5,  1'b0, 0, 13'h0,    0, 13'h0,    0, 1'b0, 5,  13'h0101};
    vt[1] = '{12'h4A0, 7'h20, CYCLE7,  1'b1, 3, 13'h0230, 0, 13'h0,    0, 1'b0, 7,  13'h0230};
    vt[2] = '{12'h123, 7'h30, CYCLE7,  1'b0, 0, 13'h0,    0, 13'h0,    2, 1'b0, 7,  13'h0231};
    vt[3] = '{12'h456, 7'h05, CYCLE12, 1'b0, 2, 13'h0555, 9, 13'h01FF, 0, 1'b0, 12, 13'h01FF};
    vt[4] = '{12'h0FF, 7'h40, CYCLE5,  1'b0, 0, 13'h0,    0, 13'h0,    0, 1'b0, 5,  13'h0100};
    vt[5] = '{12'h7E7, 7'h50, CYCLE12, 1'b1, 0, 13'h0,    0, 13'h0,    0, 1'b0, 12, 13'h0100};
    vt[6] = '{12'h321, 7'h60, CYCLE7,  1'b1, 2, 13'h0777, 6, 13'h1ABC, 0, 1'b0, 7,  13'h1ABC};
    vt[7] = '{12'h0AA, 7'h70, CYCLE5,  1'b0, 0, 13'h0,    0, 13'h0,    1, 1'b0, 5,  13'h1ABD};
    vt[8] = '{12'h999, 7'h08, CYCLE12, 1'b0, 0, 13'h0,    0, 13'h0,    0, 1'b1, 12, 13'h1ABE};

    reset_n = 1'b0; clk_en = 1'b0; halt_req = 1'b0; wake = 1'b0;
    pc_load = 1'b0; pc_load_value = '0; micro_last = 1'b0;
    drive_decode(0);
    #12;
    check("rst_rom_addr", 32'(rom_addr), 32'(13'h0100));
    check("rst_opcode", 32'(opcode), 32'(12'h000));
    check("rst_uaddr", 32'(microcode_addr), 32'(7'h00));
    check("rst_uvalid", 32'(micro_valid), 32'(1'b0));
    check("rst_instr_start", 32'(instr_start), 32'(1'b0));
    check("rst_halted", 32'(halted), 32'(1'b0));
    reset_n = 1'b1;

    tick(1'b1);
    check("first_start", 32'(instr_start), 32'(1'b1));
    check("first_fetch_pc", 32'(rom_addr), 32'(13'h0100));
    check("first_opcode", 32'(opcode), 32'(12'h0A5));
    pc_cur = 13'h0100;

    for (int i = 0; i < N; i++) begin
      e_push.ticks = vt[i].exp_ticks;
      e_push.pc    = vt[i].exp_pc;
      e_push.op    = (i + 1 < N) ? vt[i+1].op : FILL_OP;
      sb.push_back(e_push);
      drive_decode(i + 1);
      m    = (vt[i].ml != 0) ? vt[i].ml : 99;
      done = 1'b0;
      for (int t = 1; t <= 20 && !done; t++) begin
        if (vt[i].gate) begin
          for (int g = 0; g < 3; g++) begin
            pc_load = 1'b1; pc_load_value = 13'h0F0F; micro_last = 1'b1;
            tick(1'b0);
            check("gated_instr_start", 32'(instr_start), 32'(1'b0));
            check("gated_opcode", 32'(opcode), 32'(vt[i].op));
            if (t - 1 <= vt[i].exp_ticks - 2) begin
              check("gated_pc", 32'(rom_addr), 32'(pc_cur));
              check("gated_uaddr", 32'(microcode_addr), 32'(exp_ua(vt[i].sa, t - 1, m)));
              check("gated_uvalid", 32'(micro_valid), 32'((t - 1) < m));
            end
          end
        end
        pc_load       = (t == vt[i].jt) || (t == vt[i].jt2);
        pc_load_value = (t == vt[i].jt2) ? vt[i].jv2 : vt[i].jv;
        micro_last    = (t == vt[i].ml);
        tick(1'b1);
        if (instr_start) begin
          done = 1'b1;
          e = sb.pop_front();
          check("instr_ticks", t, e.ticks);
          check("next_fetch_pc", 32'(rom_addr), 32'(e.pc));
          check("next_opcode", 32'(opcode), 32'(e.op));
          pc_cur = e.pc;
        end else if (t <= vt[i].exp_ticks - 2) begin
          check("uaddr", 32'(microcode_addr), 32'(exp_ua(vt[i].sa, t, m)));
          check("uvalid", 32'(micro_valid), 32'(t < m));
          check("pc_steady", 32'(rom_addr), 32'(pc_cur));
        end
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL instr_timeout: vector %0d got no next fetch, expected one after %0d ticks", i, vt[i].exp_ticks);
        void'(sb.pop_front());
      end
    end
    pc_load = 1'b0; micro_last = 1'b0;
    check("sb_empty", sb.size(), 0);

    // Abort a CYCLE12 instruction at tick 3 with a jump already pending.
    rom_data = 12'hC3C; cycle_length = CYCLE12; skip_pc_increment = 1'b0;
    reset_n = 1'b0; #2; reset_n = 1'b1;
    tick(1'b1);
    check("rst2_fetch_start", 32'(instr_start), 32'(1'b1));
    tick(1'b1);
    pc_load = 1'b1; pc_load_value = 13'h1555;
    tick(1'b1);
    pc_load = 1'b0;
    tick(1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rom_addr", 32'(rom_addr), 32'(13'h0100));
    check("abort_opcode", 32'(opcode), 32'(12'h000));
    check("abort_uaddr", 32'(microcode_addr), 32'(7'h00));
    check("abort_uvalid", 32'(micro_valid), 32'(1'b0));
    check("abort_instr_start", 32'(instr_start), 32'(1'b0));
    check("abort_halted", 32'(halted), 32'(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    rom_data = 12'h0A5; cycle_length = CYCLE5; skip_pc_increment = 1'b0;
    tick(1'b1);
    check("post_abort_start", 32'(instr_start), 32'(1'b1));
    check("post_abort_pc", 32'(rom_addr), 32'(13'h0100));
    check("post_abort_opcode", 32'(opcode), 32'(12'h0A5));
    run_to_fetch(20, n);
    check("post_abort_ticks", n, 5);
    check("post_abort_next_pc", 32'(rom_addr), 32'(13'h0101));

`ifdef SEQ_HALT_EN
    for (int t = 1; t <= 4; t++) begin
      halt_req = (t == 2 || t == 4);
      tick(1'b1);
      if (t == 2) check("halt_nonfinal_ignored", 32'(halted), 32'(1'b0));
    end
    halt_req = 1'b0;
    check("halt_flag", 32'(halted), 32'(1'b1));
    check("halt_pc", 32'(rom_addr), 32'(13'h0102));
    check("halt_uvalid", 32'(micro_valid), 32'(1'b0));
    tick(1'b1);
    tick(1'b1);
    check("halt_hold", 32'(halted), 32'(1'b1));
    check("halt_no_start", 32'(instr_start), 32'(1'b0));
    check("halt_pc_hold", 32'(rom_addr), 32'(13'h0102));
    check("halt_opcode_hold", 32'(opcode), 32'(12'h0A5));
    wake = 1'b1;
    tick(1'b1);
    wake = 1'b0;
    check("wake_leave", 32'(halted), 32'(1'b0));
    check("wake_no_start", 32'(instr_start), 32'(1'b0));
    tick(1'b1);
    check("wake_fetch", 32'(instr_start), 32'(1'b1));
    check("wake_fetch_pc", 32'(rom_addr), 32'(13'h0102));
`else
    halt_req = 1'b1; wake = 1'b1;
    for (int t = 1; t <= 4; t++) tick(1'b1);
    check("nohalt_flag", 32'(halted), 32'(1'b0));
    run_to_fetch(10, n);
    check("nohalt_fetch_ticks", n, 1);
    check("nohalt_fetch_pc", 32'(rom_addr), 32'(13'h0102));
    halt_req = 1'b0; wake = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
